// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU boot loader: state encoding and width defaults.
package cpu_pkg;
    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_STEP_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        VERIFY_RD,
        VERIFY_CMP,
        RUN,
        ERR
    } loader_state_t;
endpackage

// File: rtl/loader_addr_counter.sv
// Per-section word index with byte-address and terminal-count outputs.
module loader_addr_counter #(
    parameter int MAX_WORDS = 512,
    parameter int ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] addr,
    output logic        full
);
    localparam int IW = $clog2(MAX_WORDS + 1);

    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)  idx <= '0;
        else if (clr) idx <= '0;
        else if (inc) idx <= idx + 1'b1;
    end

    assign full = (idx == IW'(MAX_WORDS));
    assign addr = 32'(idx) * 32'(ADDR_STEP);
endmodule

// File: rtl/cpu_boot_loader.sv
// Streams section 0 into imem and section 1 into dmem, then enables the CPU.
// Optional write readback verification: define LOADER_READBACK_EN.
module cpu_boot_loader
    import cpu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int ADDR_STEP  = ADDR_STEP_DEF
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2,
    output logic              cpu_enable,
    output logic              busy,
    output logic              err
);
    loader_state_t state_q, state_d;

    logic        accept, start_ok, ovf, mismatch;
    logic        wr_i, wr_d, rd_i, rd_d, full_i, full_d;
    logic [31:0] addr_i, addr_d, rb_addr;

    // Halt takes priority over a word presented in the same cycle, so no partial write.
    assign s_ready  = (state_q == LOAD_I || state_q == LOAD_D) && !halt;
    assign accept   = s_valid && s_ready;
    assign start_ok = (state_q == IDLE) && start && !halt;
    assign wr_i     = accept && (state_q == LOAD_I) && !full_i;
    assign wr_d     = accept && (state_q == LOAD_D) && !full_d;
    assign ovf      = accept && ((state_q == LOAD_I) ? full_i : full_d);

    loader_addr_counter #(.MAX_WORDS(IMEM_WORDS), .ADDR_STEP(ADDR_STEP)) u_cnt_i (
        .clk(clk), .arst_n(arst_n), .clr(start_ok), .inc(wr_i), .addr(addr_i), .full(full_i)
    );
    loader_addr_counter #(.MAX_WORDS(DMEM_WORDS), .ADDR_STEP(ADDR_STEP)) u_cnt_d (
        .clk(clk), .arst_n(arst_n), .clr(start_ok), .inc(wr_d), .addr(addr_d), .full(full_d)
    );

`ifdef LOADER_READBACK_EN
    logic [DATA_W-1:0] rb_data;
    logic              rb_last, rb_sec;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rb_addr <= '0;
            rb_data <= '0;
            rb_last <= 1'b0;
            rb_sec  <= 1'b0;
        end else if (wr_i || wr_d) begin
            rb_addr <= wr_i ? addr_i : addr_d;
            rb_data <= s_data;
            rb_last <= s_last;
            rb_sec  <= wr_d;
        end
    end

    assign rd_i     = (state_q == VERIFY_RD) && !rb_sec;
    assign rd_d     = (state_q == VERIFY_RD) && rb_sec;
    assign mismatch = (state_q == VERIFY_CMP) && ((rb_sec ? rdata_ext_2 : rdata_ext) != rb_data);
`else
    logic unused_rdata;
    assign unused_rdata = ^{rdata_ext, rdata_ext_2};
    assign rb_addr      = '0;
    assign rd_i         = 1'b0;
    assign rd_d         = 1'b0;
    assign mismatch     = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start_ok) state_d = LOAD_I;
            LOAD_I, LOAD_D: begin
                if (halt)     state_d = IDLE;
                else if (ovf) state_d = ERR;
                else if (accept) begin
`ifdef LOADER_READBACK_EN
                    state_d = VERIFY_RD;
`else
                    if (s_last) state_d = (state_q == LOAD_I) ? LOAD_D : RUN;
`endif
                end
            end
`ifdef LOADER_READBACK_EN
            VERIFY_RD:  state_d = halt ? IDLE : VERIFY_CMP;
            VERIFY_CMP: begin
                if (halt)          state_d = IDLE;
                else if (mismatch) state_d = ERR;
                else if (rb_last)  state_d = rb_sec ? RUN : LOAD_D;
                else               state_d = rb_sec ? LOAD_D : LOAD_I;
            end
`endif
            RUN, ERR: if (halt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)              err <= 1'b0;
        else if (start_ok)        err <= 1'b0;
        else if (ovf || mismatch) err <= 1'b1;
    end

    assign wen_ext     = wr_i;
    assign ren_ext     = rd_i;
    assign wdata_ext   = wr_i ? s_data : '0;
    assign addr_ext    = wr_i ? addr_i : (rd_i ? rb_addr : 32'd0);
    assign wen_ext_2   = wr_d;
    assign ren_ext_2   = rd_d;
    assign wdata_ext_2 = wr_d ? s_data : '0;
    assign addr_ext_2  = wr_d ? addr_d : (rd_d ? rb_addr : 32'd0);

    assign cpu_enable  = (state_q == RUN);
    assign busy        = (state_q == LOAD_I) || (state_q == LOAD_D) ||
                         (state_q == VERIFY_RD) || (state_q == VERIFY_CMP);
endmodule
